// File: rtl/seq_divider16.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Define SIGNED_DIV_EN for two's-complement operands (adds one sign fix-up cycle).
module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovfl
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovfl_q, ovfl_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

`ifdef SIGNED_DIV_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic ovfp_q, ovfp_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction
`endif

    // Partial remainder always stays below the divisor, so WIDTH bits hold it;
    // only the shifted trial value needs the extra bit.
    always_comb begin
        r_shift = {r_q, q_q[WIDTH-1]};
        trial   = r_shift - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            r_step = trial[WIDTH-1:0];
            q_step = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_step = r_shift[WIDTH-1:0];
            q_step = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovfl_d  = ovfl_q;
`ifdef SIGNED_DIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovfp_d  = ovfp_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = StDone;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        ovfl_d  = 1'b0;
                    end else begin
                        state_d = StRun;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH);
`ifdef SIGNED_DIV_EN
                        q_d     = mag(dividend);
                        dvs_d   = mag(divisor);
                        qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_d  = dividend[WIDTH-1];
                        ovfp_d  = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`else
                        q_d     = dividend;
                        dvs_d   = divisor;
`endif
                    end
                end
            end
            StRun: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef SIGNED_DIV_EN
                    state_d = StFix;
`else
                    state_d = StDone;
                    quo_d   = q_step;
                    rem_d   = r_step;
                    dbz_d   = 1'b0;
                    ovfl_d  = 1'b0;
`endif
                end
            end
            StFix: begin
`ifdef SIGNED_DIV_EN
                // Most-negative / -1 falls out naturally: magnitude 2^(W-1) with no negation.
                state_d = StDone;
                quo_d   = qneg_q ? -q_q : q_q;
                rem_d   = rneg_q ? -r_q : r_q;
                dbz_d   = 1'b0;
                ovfl_d  = ovfp_q;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovfl_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovfp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovfl_q  <= ovfl_d;
`ifdef SIGNED_DIV_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovfp_q  <= ovfp_d;
`endif
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign ovfl        = ovfl_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Directed self-checking bench for seq_divider16 (unsigned, or signed with SIGNED_DIV_EN).
module tb_seq_divider16;

`ifdef SIGNED_DIV_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        ovfl;

    int pass_cnt  = 0;
    int total_cnt = 0;

    seq_divider16 #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .ovfl       (ovfl)
    );

    always #5 clk = ~clk;

    // Drive operands with start for one accept edge; caller decides when to drop start.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; latency counts the accept edge as 1.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if ({busy, done, quotient, remainder, div_by_zero, ovfl} !== 36'd0)
                $display("FAIL reset_outputs cyc=%0d got=%h required=0", i,
                         {busy, done, quotient, remainder, div_by_zero, ovfl});
            else pass_cnt++;
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_release busy/done got=%b required=00",
                                             {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_unsigned();
        int lat, bc;
        launch(16'd1000, 16'd7);
        start = 1'b0;
        total_cnt++;
        if (quotient !== 16'd0 || busy !== 1'b1)
            $display("FAIL hold_before_done q=%0d busy=%b required q=0 busy=1", quotient, busy);
        else pass_cnt++;
        wait_done(lat, bc);
        total_cnt++;
        if (lat !== LAT) $display("FAIL unsigned_latency got=%0d required=%0d", lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 16) $display("FAIL busy_cycles got=%0d required=16", bc);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 16'd142 || remainder !== 16'd6 || div_by_zero !== 1'b0 || ovfl !== 1'b0)
            $display("FAIL unsigned_1000_7 q=%0d r=%0d dbz=%b ov=%b required q=142 r=6 dbz=0 ov=0",
                     quotient, remainder, div_by_zero, ovfl);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (done !== 1'b0 || quotient !== 16'd142 || remainder !== 16'd6)
            $display("FAIL done_pulse_hold done=%b q=%0d r=%0d required done=0 q=142 r=6",
                     done, quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int lat, bc;
        launch(16'h1234, 16'h0000);
        start = 1'b0;
        wait_done(lat, bc);
        total_cnt++;
        if (lat !== 1) $display("FAIL dbz_latency got=%0d required=1", lat);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 16'hFFFF || remainder !== 16'h1234 || div_by_zero !== 1'b1 ||
            ovfl !== 1'b0)
            $display("FAIL dbz_results q=%h r=%h dbz=%b ov=%b required q=ffff r=1234 dbz=1 ov=0",
                     quotient, remainder, div_by_zero, ovfl);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (done !== 1'b0 || div_by_zero !== 1'b1)
            $display("FAIL dbz_hold done=%b dbz=%b required done=0 dbz=1", done, div_by_zero);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        launch(16'hFFFF, 16'h0001);
        // Start stays high with new operands; they must be ignored until the done cycle.
        dividend = 16'd5;
        divisor  = 16'd10;
        wait_done(lat, bc);
        total_cnt++;
        if (lat !== LAT || quotient !== 16'hFFFF || remainder !== 16'h0000 || div_by_zero !== 1'b0)
            $display("FAIL held_start lat=%0d q=%h r=%h dbz=%b required lat=%0d q=ffff r=0 dbz=0",
                     lat, quotient, remainder, div_by_zero, LAT);
        else pass_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_accept done=%b busy=%b required done=0 busy=1", done, busy);
        else pass_cnt++;
        wait_done(lat, bc);
        total_cnt++;
        if (lat !== LAT || quotient !== 16'd0 || remainder !== 16'd5)
            $display("FAIL b2b_5_10 lat=%0d q=%0d r=%0d required lat=%0d q=0 r=5",
                     lat, quotient, remainder, LAT);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int seen;
        launch(16'd500, 16'd3);
        start = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, quotient, remainder, div_by_zero, ovfl} !== 36'd0)
            $display("FAIL abort_outputs got=%h required=0",
                     {busy, done, quotient, remainder, div_by_zero, ovfl});
        else pass_cnt++;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL abort_no_done active_cycles=%0d required=0", seen);
        else pass_cnt++;
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        int lat, bc;
        launch(16'hFFF9, 16'h0002);
        start = 1'b0;
        wait_done(lat, bc);
        total_cnt++;
        if (lat !== 18 || quotient !== 16'hFFFD || remainder !== 16'hFFFF || ovfl !== 1'b0)
            $display("FAIL signed_m7_2 lat=%0d q=%h r=%h ov=%b required lat=18 q=fffd r=ffff ov=0",
                     lat, quotient, remainder, ovfl);
        else pass_cnt++;
        @(posedge clk);
        #1;
        launch(16'h8000, 16'hFFFF);
        start = 1'b0;
        wait_done(lat, bc);
        total_cnt++;
        if (lat !== 18 || quotient !== 16'h8000 || remainder !== 16'h0000 || ovfl !== 1'b1)
            $display("FAIL signed_ovfl lat=%0d q=%h r=%h ov=%b required lat=18 q=8000 r=0 ov=1",
                     lat, quotient, remainder, ovfl);
        else pass_cnt++;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_unsigned();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
